// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order and the hex glyph table.
// Used by both the scan decoder and the binary-to-7-segment encoder.
package seg7_pkg;

   // Segment lines as driven on the bus, MSB first: {g,f,e,d,c,b,a}, active-high.
   typedef struct packed {
      logic g;
      logic f;
      logic e;
      logic d;
      logic c;
      logic b;
      logic a;
   } seg7_t;

   localparam logic [6:0] SegHex0 = 7'h3F;
   localparam logic [6:0] SegHex1 = 7'h06;
   localparam logic [6:0] SegHex2 = 7'h5B;
   localparam logic [6:0] SegHex3 = 7'h4F;
   localparam logic [6:0] SegHex4 = 7'h66;
   localparam logic [6:0] SegHex5 = 7'h6D;
   localparam logic [6:0] SegHex6 = 7'h7D;
   localparam logic [6:0] SegHex7 = 7'h07;
   localparam logic [6:0] SegHex8 = 7'h7F;
   localparam logic [6:0] SegHex9 = 7'h6F;
   localparam logic [6:0] SegHexA = 7'h77;
   localparam logic [6:0] SegHexB = 7'h7C;
   localparam logic [6:0] SegHexC = 7'h39;
   localparam logic [6:0] SegHexD = 7'h5E;
   localparam logic [6:0] SegHexE = 7'h79;
   localparam logic [6:0] SegHexF = 7'h71;
   localparam logic [6:0] SegOff  = 7'h00;

   // Digit index width; enough for up to eight digit positions.
   localparam int unsigned IdxW = 3;

endpackage

// File: rtl/seg7_to_bin.sv
// Combinational seven-segment pattern to hex nibble decoder.
// All-off reports blank, unknown glyphs report bad; both give nibble 0.
module seg7_to_bin (
   input  logic [6:0] segments,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       bad
);
   import seg7_pkg::*;

   seg7_t pat;
   assign pat = seg7_t'(segments);

   // Table lookup of the sixteen hex glyphs plus the blank pattern.
   always_comb begin
      nibble = 4'h0;
      blank  = 1'b0;
      bad    = 1'b0;
      case (pat)
         SegHex0: nibble = 4'h0;
         SegHex1: nibble = 4'h1;
         SegHex2: nibble = 4'h2;
         SegHex3: nibble = 4'h3;
         SegHex4: nibble = 4'h4;
         SegHex5: nibble = 4'h5;
         SegHex6: nibble = 4'h6;
         SegHex7: nibble = 4'h7;
         SegHex8: nibble = 4'h8;
         SegHex9: nibble = 4'h9;
         SegHexA: nibble = 4'hA;
         SegHexB: nibble = 4'hB;
         SegHexC: nibble = 4'hC;
         SegHexD: nibble = 4'hD;
         SegHexE: nibble = 4'hE;
         SegHexF: nibble = 4'hF;
         SegOff:  blank  = 1'b1;
         default: bad    = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a multiplexed seven-segment display into a decoded frame.
// Inputs are synchronised, debounced per digit, assembled in scan order and
// handed to the consumer through a valid/ready register with overrun flag.
module seg7_scan_decoder #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [6:0]                segments,
   input  logic [NUM_DIGITS-1:0]     digit_sel,
   output logic [4*NUM_DIGITS-1:0]   value,
   output logic [NUM_DIGITS-1:0]     blank,
   output logic [NUM_DIGITS-1:0]     bad,
   output logic                      valid,
   input  logic                      ready,
   output logic                      overrun
);
   import seg7_pkg::*;

   typedef enum logic [0:0] {StSync, StCollect} state_e;

   localparam logic [7:0]      CntMax  = 8'(STABLE_CYCLES);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

   logic [6:0]            seg_s1, seg_s2, seg_prev;
   logic [NUM_DIGITS-1:0] sel_s1, sel_s2, sel_prev;

   // Two-flop synchronisers plus one more stage to compare against last cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_s1   <= '0;
         seg_s2   <= '0;
         seg_prev <= '0;
         sel_s1   <= '0;
         sel_s2   <= '0;
         sel_prev <= '0;
      end else begin
         seg_s1   <= segments;
         seg_s2   <= seg_s1;
         seg_prev <= seg_s2;
         sel_s1   <= digit_sel;
         sel_s2   <= sel_s1;
         sel_prev <= sel_s2;
      end
   end

   logic [3:0]      ones;
   logic [IdxW-1:0] cap_idx;
   logic            same;

   // Count active strobes and find the strobed digit index.
   always_comb begin
      ones    = '0;
      cap_idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (sel_s2[k]) begin
            ones    = ones + 4'd1;
            cap_idx = IdxW'(k);
         end
      end
   end

   assign same = ({sel_s2, seg_s2} == {sel_prev, seg_prev});

   logic [7:0] cnt_q, cnt_d;
   logic       capture;

   // Stability counter: clears on any change or non-one-hot strobe, saturates at max.
   always_comb begin
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (!same || (ones != 4'd1)) begin
         cnt_d = '0;
      end else begin
         if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 8'd1;
         end
         capture = (cnt_q == CntMax - 8'd1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   logic [3:0] dec_nibble;
   logic       dec_blank, dec_bad;

   seg7_to_bin u_seg7_to_bin (
      .segments (seg_s2),
      .nibble   (dec_nibble),
      .blank    (dec_blank),
      .bad      (dec_bad)
   );

   state_e          state_q, state_d;
   logic [IdxW-1:0] exp_q, exp_d;
   logic            store;
   logic            complete_q, complete_d;

   // Frame assembly FSM: only an in-order scan starting at digit 0 completes.
   always_comb begin
      state_d    = state_q;
      exp_d      = exp_q;
      store      = 1'b0;
      complete_d = 1'b0;
      if (capture) begin
         case (state_q)
            StSync: begin
               if (cap_idx == '0) begin
                  store = 1'b1;
                  if (LastIdx == '0) begin
                     complete_d = 1'b1;
                  end else begin
                     exp_d   = IdxW'(1);
                     state_d = StCollect;
                  end
               end
            end
            StCollect: begin
               if (cap_idx == exp_q) begin
                  store = 1'b1;
                  if (exp_q == LastIdx) begin
                     complete_d = 1'b1;
                     exp_d      = '0;
                     state_d    = StSync;
                  end else begin
                     exp_d = exp_q + IdxW'(1);
                  end
               end else if (cap_idx == '0) begin
                  // A new scan began early; restart the frame from this digit.
                  store = 1'b1;
                  exp_d = IdxW'(1);
               end else begin
                  exp_d   = '0;
                  state_d = StSync;
               end
            end
            default: state_d = StSync;
         endcase
      end
   end

   // FSM state, expected index and completion strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StSync;
         exp_q      <= '0;
         complete_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         exp_q      <= exp_d;
         complete_q <= complete_d;
      end
   end

   logic [4*NUM_DIGITS-1:0] frame_val;
   logic [NUM_DIGITS-1:0]   frame_blank, frame_bad;

   // Working frame: write the captured digit into its slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_val   <= '0;
         frame_blank <= '0;
         frame_bad   <= '0;
      end else if (store) begin
         frame_val[4*cap_idx +: 4] <= dec_nibble;
         frame_blank[cap_idx]      <= dec_blank;
         frame_bad[cap_idx]        <= dec_bad;
      end
   end

   logic [4*NUM_DIGITS-1:0] value_q;
   logic [NUM_DIGITS-1:0]   blank_q, bad_q;
   logic                    valid_q, overrun_q;
   logic                    load;

   assign load = complete_q && (!valid_q || ready);

   // Output handshake register; a frame finishing while one is pending is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         value_q   <= '0;
         blank_q   <= '0;
         bad_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= complete_q && valid_q && !ready;
         if (load) begin
            value_q <= frame_val;
            blank_q <= frame_blank;
            bad_q   <= frame_bad;
            valid_q <= 1'b1;
         end else if (valid_q && ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign value   = value_q;
   assign blank   = blank_q;
   assign bad     = bad_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with default parameters.
module tb_seg7_scan_decoder;

   logic        clk;
   logic        reset;
   logic [6:0]  segments;
   logic [3:0]  digit_sel;
   logic [15:0] value;
   logic [3:0]  blank;
   logic [3:0]  bad;
   logic        valid;
   logic        ready;
   logic        overrun;

   int n_tests;
   int n_fail;

   // Accepted-frame and overrun log, sampled on the active edge.
   int          accepts;
   int          overruns;
   logic [15:0] last_value;
   logic [3:0]  last_blank;
   logic [3:0]  last_bad;

   seg7_scan_decoder #(
      .NUM_DIGITS    (4),
      .STABLE_CYCLES (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .segments  (segments),
      .digit_sel (digit_sel),
      .value     (value),
      .blank     (blank),
      .bad       (bad),
      .valid     (valid),
      .ready     (ready),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset) begin
         if (valid && ready) begin
            accepts    <= accepts + 1;
            last_value <= value;
            last_blank <= blank;
            last_bad   <= bad;
         end
         if (overrun) begin
            overruns <= overruns + 1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic [6:0] pat, input int cycles);
      logic [3:0] s;
      s         = '0;
      s[k]      = 1'b1;
      digit_sel = s;
      segments  = pat;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      digit_sel = '0;
      segments  = '0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
      drive(0, p0, 20);
      drive(1, p1, 20);
      drive(2, p2, 20);
      drive(3, p3, 20);
   endtask

   int base;
   int base_ovr;

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      accepts    = 0;
      overruns   = 0;
      last_value = '0;
      last_blank = '0;
      last_bad   = '0;
      reset      = 1'b1;
      segments   = '0;
      digit_sel  = '0;
      ready      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_value", 32'(value), 32'h0);
      check_eq("reset_blank", 32'(blank), 32'h0);
      check_eq("reset_bad", 32'(bad), 32'h0);
      check_eq("reset_valid", 32'(valid), 32'h0);
      check_eq("reset_overrun", 32'(overrun), 32'h0);
      reset = 1'b0;
      idle(4);

      // Clean scan 0..3 -> 3210
      base = accepts;
      scan4(7'h3F, 7'h06, 7'h5B, 7'h4F);
      idle(10);
      check_eq("clean_accepts", 32'(accepts - base), 32'd1);
      check_eq("clean_value", 32'(last_value), 32'h3210);
      check_eq("clean_blank", 32'(last_blank), 32'h0);
      check_eq("clean_bad", 32'(last_bad), 32'h0);
      check_eq("clean_valid_low", 32'(valid), 32'h0);
      check_eq("clean_no_overrun", 32'(overruns), 32'd0);

      // Digit 2 never settles -> no frame; then a clean scan -> 9876
      base = accepts;
      drive(0, 7'h3F, 20);
      drive(1, 7'h06, 20);
      for (int i = 0; i < 8; i++) begin
         drive(2, (i % 2 == 0) ? 7'h5B : 7'h7F, 5);
      end
      drive(3, 7'h4F, 20);
      idle(10);
      check_eq("unstable_no_frame", 32'(accepts - base), 32'd0);
      check_eq("unstable_valid_low", 32'(valid), 32'h0);
      scan4(7'h7D, 7'h07, 7'h7F, 7'h6F);
      idle(10);
      check_eq("after_unstable_accepts", 32'(accepts - base), 32'd1);
      check_eq("after_unstable_value", 32'(last_value), 32'h9876);

      // Skipped digit -> discarded; then clean scan -> DCBA
      base = accepts;
      drive(0, 7'h3F, 20);
      drive(1, 7'h06, 20);
      drive(3, 7'h4F, 20);
      idle(10);
      check_eq("skip_no_frame", 32'(accepts - base), 32'd0);
      scan4(7'h77, 7'h7C, 7'h39, 7'h5E);
      idle(10);
      check_eq("after_skip_accepts", 32'(accepts - base), 32'd1);
      check_eq("after_skip_value", 32'(last_value), 32'hDCBA);

      // Blank and bad glyphs
      base = accepts;
      scan4(7'h79, 7'h55, 7'h71, 7'h00);
      idle(10);
      check_eq("flags_accepts", 32'(accepts - base), 32'd1);
      check_eq("flags_value", 32'(last_value), 32'h0F0E);
      check_eq("flags_blank", 32'(last_blank), 32'h8);
      check_eq("flags_bad", 32'(last_bad), 32'h2);

      // Back-pressure: second frame dropped with a single overrun pulse
      base     = accepts;
      base_ovr = overruns;
      ready    = 1'b0;
      scan4(7'h66, 7'h6D, 7'h7D, 7'h07);
      idle(5);
      check_eq("bp_first_valid", 32'(valid), 32'h1);
      check_eq("bp_first_value", 32'(value), 32'h7654);
      scan4(7'h3F, 7'h3F, 7'h3F, 7'h3F);
      idle(10);
      check_eq("bp_held_valid", 32'(valid), 32'h1);
      check_eq("bp_held_value", 32'(value), 32'h7654);
      check_eq("bp_overrun_once", 32'(overruns - base_ovr), 32'd1);
      check_eq("bp_no_accept", 32'(accepts - base), 32'd0);
      ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_valid_drops", 32'(valid), 32'h0);
      check_eq("bp_accept_value", 32'(last_value), 32'h7654);
      check_eq("bp_accepts", 32'(accepts - base), 32'd1);

      // Reset mid-frame after digit 2 capture
      base = accepts;
      drive(0, 7'h06, 20);
      drive(1, 7'h5B, 20);
      drive(2, 7'h4F, 20);
      reset     = 1'b1;
      digit_sel = '0;
      segments  = '0;
      @(posedge clk);
      #1;
      check_eq("midreset_value", 32'(value), 32'h0);
      check_eq("midreset_blank", 32'(blank), 32'h0);
      check_eq("midreset_bad", 32'(bad), 32'h0);
      check_eq("midreset_valid", 32'(valid), 32'h0);
      check_eq("midreset_overrun", 32'(overrun), 32'h0);
      reset = 1'b0;
      drive(2, 7'h4F, 20);
      drive(3, 7'h66, 20);
      idle(10);
      check_eq("midreset_no_frame", 32'(accepts - base), 32'd0);
      check_eq("midreset_valid_low", 32'(valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
